// File: rtl/pcpi_op2_bridge.sv
// pcpi_op2_bridge: PCPI co-processor front end for an a/b + c/d engine.
// Decodes the custom instruction, launches the four 16-bit operands to the
// engine with a strobe/busy handshake, collects the 16-bit result and answers
// the CPU with a one-cycle pcpi_ready/pcpi_wr pulse.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   pcpi_valid/insn/rs1/rs2  CPU request (rs1 = {a,b}, rs2 = {c,d})
//   pcpi_wr/rd/wait/ready    CPU response, all registered
//   op_a..op_d, op_input_STB operands and launch strobe to the engine
//   op_BUSY                  engine has taken the operands
//   op_output_result/STB     engine result and its valid strobe
//   op_result_BUSY           bridge not ready for a result
//   op_timeout               sticky abort flag
//
// Optional feature: define OP2_TIMEOUT_EN to enable the TIMEOUT_CYCLES
// watchdog; without it the bridge waits indefinitely and op_timeout is 0.
module pcpi_op2_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pcpi_valid,
   input  logic [31:0] pcpi_insn,
   input  logic [31:0] pcpi_rs1,
   input  logic [31:0] pcpi_rs2,
   output logic        pcpi_wr,
   output logic [31:0] pcpi_rd,
   output logic        pcpi_wait,
   output logic        pcpi_ready,
   output logic [15:0] op_a,
   output logic [15:0] op_b,
   output logic [15:0] op_c,
   output logic [15:0] op_d,
   output logic        op_input_STB,
   input  logic        op_BUSY,
   input  logic [15:0] op_output_result,
   input  logic        op_output_STB,
   output logic        op_result_BUSY,
   output logic        op_timeout
);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_RES, RESP} state_t;

   state_t r_state;
   logic   r_drop;   // CPU withdrew the request; finish the engine side silently
   logic   w_match;

   assign w_match = (pcpi_insn[6:0]   == 7'b0001011) &&
                    (pcpi_insn[14:12] == 3'b000)     &&
                    (pcpi_insn[31:25] == 7'b0000010);

`ifdef OP2_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_cnt;
`else
   logic w_unused_ok;
   assign w_unused_ok = &{1'b0, (TIMEOUT_CYCLES == 0)};
   assign op_timeout  = 1'b0;
`endif

   // Register fields not used by the decode are intentionally ignored.
   logic w_unused_insn;
   assign w_unused_insn = &{1'b0, pcpi_insn[24:15], pcpi_insn[11:7]};

   // Single-process state machine; every output is a flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= IDLE;
         r_drop         <= 1'b0;
         op_input_STB   <= 1'b0;
         op_result_BUSY <= 1'b1;
         pcpi_wait      <= 1'b0;
         pcpi_ready     <= 1'b0;
         pcpi_wr        <= 1'b0;
         pcpi_rd        <= 32'h0;
         op_a           <= 16'h0;
         op_b           <= 16'h0;
         op_c           <= 16'h0;
         op_d           <= 16'h0;
`ifdef OP2_TIMEOUT_EN
         op_timeout     <= 1'b0;
         r_cnt          <= '0;
`endif
      end else begin
         // Completion pulse lasts exactly the RESP cycle.
         pcpi_ready <= 1'b0;
         pcpi_wr    <= 1'b0;

         case (r_state)
            IDLE: begin
               if (pcpi_valid && w_match) begin
                  op_a         <= pcpi_rs1[31:16];
                  op_b         <= pcpi_rs1[15:0];
                  op_c         <= pcpi_rs2[31:16];
                  op_d         <= pcpi_rs2[15:0];
                  op_input_STB <= 1'b1;
                  pcpi_wait    <= 1'b1;
                  r_drop       <= 1'b0;
                  r_state      <= SEND;
               end
            end

            SEND: begin
               if (!pcpi_valid) begin
                  r_drop    <= 1'b1;
                  pcpi_wait <= 1'b0;
               end
               if (op_BUSY) begin
                  op_input_STB   <= 1'b0;
                  op_result_BUSY <= 1'b0;
                  r_state        <= WAIT_RES;
               end
            end

            WAIT_RES: begin
               if (!pcpi_valid) begin
                  r_drop    <= 1'b1;
                  pcpi_wait <= 1'b0;
               end
               if (op_output_STB && !op_result_BUSY) begin
                  op_result_BUSY <= 1'b1;
                  pcpi_wait      <= 1'b0;
                  if (r_drop || !pcpi_valid) begin
                     r_state <= IDLE;
                  end else begin
                     pcpi_rd    <= {16'h0000, op_output_result};
                     pcpi_ready <= 1'b1;
                     pcpi_wr    <= 1'b1;
                     r_state    <= RESP;
                  end
               end
            end

            RESP: begin
               r_state <= IDLE;
            end

            default: begin
               r_state <= IDLE;
            end
         endcase

`ifdef OP2_TIMEOUT_EN
         // Watchdog overrides the handshake once the budget is spent.
         if ((r_state == SEND) || (r_state == WAIT_RES)) begin
            if (r_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
               op_input_STB   <= 1'b0;
               op_result_BUSY <= 1'b1;
               op_timeout     <= 1'b1;
               pcpi_wait      <= 1'b0;
               if (r_drop || !pcpi_valid) begin
                  r_state <= IDLE;
               end else begin
                  pcpi_rd    <= 32'hFFFF_FFFF;
                  pcpi_ready <= 1'b1;
                  pcpi_wr    <= 1'b1;
                  r_state    <= RESP;
               end
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end else begin
            r_cnt <= '0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_pcpi_op2_bridge.sv
// Directed testbench for pcpi_op2_bridge; the engine side is driven by hand.
module tb_pcpi_op2_bridge;

   localparam int unsigned TB_TIMEOUT = 64;
   localparam logic [31:0] INSN_MATCH  = 32'h0400_000B;
   localparam logic [31:0] INSN_MATCH2 = 32'h04C5_8F8B;
   localparam logic [31:0] INSN_F7BAD  = 32'h0200_000B;
   localparam logic [31:0] INSN_F3BAD  = 32'h0400_100B;

   logic        clk = 1'b0;
   logic        rst;
   logic        pcpi_valid;
   logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
   logic        pcpi_wr, pcpi_wait, pcpi_ready;
   logic [31:0] pcpi_rd;
   logic [15:0] op_a, op_b, op_c, op_d;
   logic        op_input_STB, op_BUSY, op_output_STB, op_result_BUSY, op_timeout;
   logic [15:0] op_output_result;

   int n_checks = 0;
   int n_errors = 0;

   pcpi_op2_bridge #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
      .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
      .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
      .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
      .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
      .op_input_STB(op_input_STB), .op_BUSY(op_BUSY),
      .op_output_result(op_output_result), .op_output_STB(op_output_STB),
      .op_result_BUSY(op_result_BUSY), .op_timeout(op_timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
      pcpi_valid = 1'b1;
      pcpi_insn  = insn;
      pcpi_rs1   = rs1;
      pcpi_rs2   = rs2;
      tick();
   endtask

   // Engine takes operands next edge, then returns a result the edge after.
   task automatic complete(input logic [15:0] res);
      op_BUSY = 1'b1;
      tick();
      op_output_result = res;
      op_output_STB    = 1'b1;
      tick();
      op_output_STB = 1'b0;
      op_BUSY       = 1'b0;
   endtask

   task automatic idle_cpu();
      pcpi_valid = 1'b0;
      tick();
   endtask

   logic        seen;
   logic [63:0] ops_now;

   initial begin
      rst = 1'b1;
      pcpi_valid = 1'b0; pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;
      op_BUSY = 1'b0; op_output_STB = 1'b0; op_output_result = '0;
      tick(); tick();
      rst = 1'b0;
      tick();

      // Reset values
      check("rst_ready", 32'(pcpi_ready), 32'd0);
      check("rst_wait", 32'(pcpi_wait), 32'd0);
      check("rst_rd", pcpi_rd, 32'h0);
      check("rst_stb", 32'(op_input_STB), 32'd0);
      check("rst_resbusy", 32'(op_result_BUSY), 32'd1);
      check("rst_opa", 32'(op_a), 32'h0);
      check("rst_timeout", 32'(op_timeout), 32'd0);

      // Basic operation, 20-cycle engine latency
      launch(INSN_MATCH, 32'h0008_0002, 32'h0009_0003);
      check("t1_stb", 32'(op_input_STB), 32'd1);
      check("t1_wait", 32'(pcpi_wait), 32'd1);
      check("t1_ops", {op_a, op_b}, 32'h0008_0002);
      check("t1_ops2", {op_c, op_d}, 32'h0009_0003);
      op_BUSY = 1'b1;
      tick();
      check("t1_stb_clr", 32'(op_input_STB), 32'd0);
      check("t1_resbusy_clr", 32'(op_result_BUSY), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         seen |= pcpi_ready;
      end
      check("t1_early_ready", 32'(seen), 32'd0);
      op_output_result = 16'h1234;
      op_output_STB    = 1'b1;
      tick();
      check("t1_ready", 32'(pcpi_ready), 32'd1);
      check("t1_wr", 32'(pcpi_wr), 32'd1);
      check("t1_rd", pcpi_rd, 32'h0000_1234);
      check("t1_wait_clr", 32'(pcpi_wait), 32'd0);
      check("t1_resbusy_set", 32'(op_result_BUSY), 32'd1);
      op_output_STB = 1'b0; op_BUSY = 1'b0;
      idle_cpu();
      check("t1_ready_pulse", 32'(pcpi_ready), 32'd0);
      check("t1_wr_pulse", 32'(pcpi_wr), 32'd0);
      check("t1_rd_hold", pcpi_rd, 32'h0000_1234);

      // Back-to-back: request held through RESP is re-accepted in IDLE
      launch(INSN_MATCH2, 32'h0001_0002, 32'h0003_0004);
      complete(16'h00AB);
      check("t2_rd1", pcpi_rd, 32'h0000_00AB);
      check("t2_ready1", 32'(pcpi_ready), 32'd1);
      pcpi_rs1 = 32'h0005_0006; pcpi_rs2 = 32'h0007_0008;
      tick();
      check("t2_resp_end", 32'(pcpi_ready), 32'd0);
      tick();
      check("t2_relaunch", 32'(op_input_STB), 32'd1);
      check("t2_ops", {op_a, op_d}, 32'h0005_0008);
      complete(16'h0055);
      check("t2_rd2", pcpi_rd, 32'h0000_0055);
      idle_cpu();

      // Non-matching instructions are ignored
      pcpi_valid = 1'b1; pcpi_insn = INSN_F7BAD;
      pcpi_rs1 = 32'hAAAA_BBBB; pcpi_rs2 = 32'hCCCC_DDDD;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (i == 15) pcpi_insn = INSN_F3BAD;
         tick();
         seen |= op_input_STB | pcpi_wait | pcpi_ready;
      end
      check("t3_nomatch", 32'(seen), 32'd0);
      check("t3_ops_hold", {op_a, op_d}, 32'h0005_0008);
      idle_cpu();

      // Engine delays op_BUSY by 5 cycles; stray result strobe in SEND ignored
      launch(INSN_MATCH, 32'h1111_2222, 32'h3333_4444);
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         op_output_STB = (i == 2);
         op_output_result = 16'hDEAD;
         tick();
         ops_now = {op_a, op_b, op_c, op_d};
         if (op_input_STB !== 1'b1 || ops_now !== 64'h1111_2222_3333_4444 || pcpi_ready !== 1'b0)
            seen = 1'b1;
      end
      check("t4_stb_hold", 32'(seen), 32'd0);
      op_output_STB = 1'b0;
      op_BUSY = 1'b1;
      tick();
      check("t4_stb_clr", 32'(op_input_STB), 32'd0);
      op_output_result = 16'h0777;
      op_output_STB = 1'b1;
      tick();
      op_output_STB = 1'b0; op_BUSY = 1'b0;
      check("t4_rd", pcpi_rd, 32'h0000_0777);
      idle_cpu();

      // CPU drops request in WAIT_RES: result discarded, no pulse
      launch(INSN_MATCH, 32'h0004_0002, 32'h0006_0003);
      op_BUSY = 1'b1;
      tick();
      pcpi_valid = 1'b0;
      tick();
      check("t5_wait_drop", 32'(pcpi_wait), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         seen |= pcpi_ready;
      end
      op_output_result = 16'hBEEF;
      op_output_STB = 1'b1;
      tick();
      seen |= pcpi_ready | pcpi_wr;
      op_output_STB = 1'b0; op_BUSY = 1'b0;
      check("t5_resbusy", 32'(op_result_BUSY), 32'd1);
      check("t5_rd_keep", pcpi_rd, 32'h0000_0777);
      tick();
      seen |= pcpi_ready;
      check("t5_no_ready", 32'(seen), 32'd0);
      launch(INSN_MATCH, 32'h0001_0001, 32'h0001_0001);
      check("t5_next_stb", 32'(op_input_STB), 32'd1);
      complete(16'h0042);
      check("t5_next_rd", pcpi_rd, 32'h0000_0042);
      check("t5_next_ready", 32'(pcpi_ready), 32'd1);
      idle_cpu();

      // Asynchronous reset mid WAIT_RES
      launch(INSN_MATCH, 32'h0102_0304, 32'h0506_0708);
      op_BUSY = 1'b1;
      tick();
      #2 rst = 1'b1;
      #1;
      check("t6_rd", pcpi_rd, 32'h0);
      check("t6_ops", {op_a, op_c}, 32'h0);
      check("t6_resbusy", 32'(op_result_BUSY), 32'd1);
      check("t6_wait", 32'(pcpi_wait), 32'd0);
      check("t6_stb", 32'(op_input_STB), 32'd0);
      check("t6_timeout", 32'(op_timeout), 32'd0);
      op_BUSY = 1'b0; pcpi_valid = 1'b0;
      tick();
      rst = 1'b0;
      // Result strobe in IDLE must be ignored
      op_output_result = 16'h0BAD;
      op_output_STB = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         seen |= pcpi_ready | ~op_result_BUSY;
      end
      op_output_STB = 1'b0;
      check("t6_idle_stb", 32'(seen), 32'd0);
      launch(INSN_MATCH, 32'h0002_0003, 32'h0004_0005);
      complete(16'h0101);
      check("t6_resume_rd", pcpi_rd, 32'h0000_0101);
      idle_cpu();

`ifdef OP2_TIMEOUT_EN
      // Engine never answers: watchdog aborts TB_TIMEOUT+1 cycles after launch
      launch(INSN_MATCH, 32'h0009_0009, 32'h0009_0009);
      seen = 1'b0;
      for (int i = 0; i < int'(TB_TIMEOUT); i++) begin
         tick();
         seen |= pcpi_ready;
      end
      check("t7_early", 32'(seen), 32'd0);
      tick();
      check("t7_ready", 32'(pcpi_ready), 32'd1);
      check("t7_rd", pcpi_rd, 32'hFFFF_FFFF);
      check("t7_flag", 32'(op_timeout), 32'd1);
      check("t7_stb", 32'(op_input_STB), 32'd0);
      idle_cpu();
      check("t7_sticky", 32'(op_timeout), 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pcpi_op2_bridge.md
PCPI_OP2_BRIDGE -- requirements
Module: pcpi_op2_bridge

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1024, cycles allowed between operand launch and result capture before abort (used only with OP2_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 pcpi_valid  input  1  CPU co-processor request valid; held until pcpi_ready.
REQ-005 pcpi_insn  input  32  instruction word under request.
REQ-006 pcpi_rs1  input  32  operand word 1: [31:16]=a, [15:0]=b.
REQ-007 pcpi_rs2  input  32  operand word 2: [31:16]=c, [15:0]=d.
REQ-008 pcpi_wr  output  1  rd write enable, pulsed with pcpi_ready.
REQ-009 pcpi_rd  output  32  result to CPU.
REQ-010 pcpi_wait  output  1  instruction claimed, result pending.
REQ-011 pcpi_ready  output  1  one-cycle completion pulse.
REQ-012 op_a, op_b, op_c, op_d  output  16 each  operands to the a/b+c/d engine.
REQ-013 op_input_STB  output  1  operand strobe to engine.
REQ-014 op_BUSY  input  1  engine has accepted operands / is busy.
REQ-015 op_output_result  input  16  engine result.
REQ-016 op_output_STB  input  1  engine result valid.
REQ-017 op_result_BUSY  output  1  bridge not ready for a result (drives engine's output_module_BUSY).
REQ-018 op_timeout  output  1  sticky timeout flag; constant 0 without OP2_TIMEOUT_EN.

Function
REQ-019 Decode match SHALL be pcpi_insn[6:0]=7'b0001011, [14:12]=3'b000, [31:25]=7'b0000010; any other insn SHALL leave all outputs unchanged.
REQ-020 State machine SHALL have states IDLE, SEND, WAIT_RES, RESP.
REQ-021 IDLE: on pcpi_valid and decode match, latch op_a..op_d from rs1/rs2, set op_input_STB=1, pcpi_wait=1, go SEND on that edge.
REQ-022 SEND: hold op_input_STB and operands stable; on first edge sampling op_BUSY=1, clear op_input_STB, clear op_result_BUSY, go WAIT_RES.
REQ-023 WAIT_RES: on edge sampling op_output_STB=1 and op_result_BUSY=0, capture op_output_result, set op_result_BUSY=1, go RESP.
REQ-024 RESP: for exactly one cycle drive pcpi_ready=1, pcpi_wr=1, pcpi_rd={16'h0000, captured result}, pcpi_wait=0; next edge clear pcpi_ready/pcpi_wr, go IDLE.
REQ-025 pcpi_rd SHALL hold its last value outside RESP; it is valid only while pcpi_ready=1.
REQ-026 A matching request re-presented in the IDLE cycle after RESP SHALL be accepted as a new operation (back-to-back).
REQ-027 If pcpi_valid drops in SEND or WAIT_RES, the bridge SHALL complete the engine handshake, discard the result, skip the pcpi_ready/pcpi_wr pulse, clear pcpi_wait, return to IDLE.
REQ-028 op_output_STB asserted while in IDLE or SEND SHALL be ignored (op_result_BUSY=1 there).
REQ-029 Minimum latency: pcpi_ready SHALL rise exactly one cycle after the result-capture edge; no combinational path from any input to any output.

Reset
REQ-030 rst SHALL immediately force: state IDLE, op_input_STB=0, op_result_BUSY=1, pcpi_wait=0, pcpi_ready=0, pcpi_wr=0, pcpi_rd=0, op_a..op_d=0, op_timeout=0, timeout counter=0.
REQ-031 Reset mid-operation SHALL abandon the operation with no pcpi_ready pulse; operation resumes only via a new request after rst deasserts.

Configuration
REQ-032 Macro OP2_TIMEOUT_EN: when defined, a counter SHALL run in SEND and WAIT_RES, clear on IDLE; on reaching TIMEOUT_CYCLES, clear op_input_STB, keep op_result_BUSY=1, set op_timeout=1 (sticky until rst), go RESP with pcpi_rd=32'hFFFF_FFFF.
REQ-033 Without OP2_TIMEOUT_EN: no counter, bridge waits indefinitely, op_timeout tied 0.

Verification
REQ-034 rs1=32'h0008_0002, rs2=32'h0009_0003, matching insn, engine model returns 16'h1234 after 20 cycles -> op_a..d=8,2,9,3; pcpi_rd=32'h0000_1234, single-cycle pcpi_ready/pcpi_wr.
REQ-035 Non-matching insn (funct7=7'b0000001) with pcpi_valid held 30 cycles -> op_input_STB, pcpi_wait, pcpi_ready stay 0.
REQ-036 Engine delays op_BUSY by 5 cycles -> op_input_STB held 5+ cycles, operands stable, cleared on edge after op_BUSY=1.
REQ-037 pcpi_valid dropped in WAIT_RES, engine returns 16'hBEEF -> no pcpi_ready, op_result_BUSY returns to 1, state IDLE, next request completes normally.
REQ-038 rst asserted mid WAIT_RES -> all outputs at REQ-030 values in the same cycle, op_result_BUSY=1.
REQ-039 OP2_TIMEOUT_EN, TIMEOUT_CYCLES=16, engine never raises op_output_STB -> pcpi_rd=32'hFFFF_FFFF with pcpi_ready 17 cycles after launch, op_timeout=1.
